// File: rtl/ir_cursor_mover.sv
// ir_cursor_mover: turns synchronized IR direction levels into clamped box steps,
// with auto-repeat, committing position only on the frame-start strobe.
module ir_cursor_mover #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int BOX_SIZE      = 16,
    parameter int STEP          = 4,
    parameter int X_INIT        = 312,
    parameter int Y_INIT        = 232,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic       Frame_Start,
    output logic [9:0] Box_X,
    output logic [9:0] Box_Y,
    output logic       Moved
);
    localparam int CW = $clog2(REPEAT_DELAY);
    localparam logic [9:0] XMAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] YMAX = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD - 1);
    localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [3:0] sync1, sync2;
    logic code_valid;
    logic [1:0] code_dir;
    state_t state, state_n;
    logic [1:0] dir_q, dir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic fresh, issue;
    logic pend_valid;
    logic [1:0] pend_dir;
    logic commit;
    logic [9:0] next_x, next_y;

    // Bit order {Up, Down, Left, Right}
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {Up, Down, Left, Right};
            sync2 <= sync1;
        end
    end

    assign code_valid = $onehot(sync2);
    assign code_dir = sync2[3] ? D_UP : sync2[2] ? D_DOWN : sync2[1] ? D_LEFT : D_RIGHT;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            dir_q <= D_UP;
            cnt   <= '0;
        end else begin
            state <= state_n;
            dir_q <= dir_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = code_valid ? HOLD : IDLE;
        dir_n   = code_valid ? code_dir : dir_q;
        cnt_n   = !code_valid ? cnt : fresh ? DELAY_LD : (cnt == '0) ? PERIOD_LD : cnt - CW'(1);
    end

    always_comb begin
        fresh = (state == IDLE) || (code_dir != dir_q);
        issue = code_valid && (fresh || cnt == '0);
    end

    // Latest step wins; a same-cycle commit consumes the old pending first
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_valid <= 1'b0;
            pend_dir   <= D_UP;
        end else begin
            pend_valid <= issue || (pend_valid && !Frame_Start);
            pend_dir   <= issue ? code_dir : pend_dir;
        end
    end

    assign commit = Frame_Start && pend_valid;

    always_comb begin
        next_x = (pend_dir == D_LEFT) ? ((Box_X < STEP_W) ? '0 : Box_X - STEP_W) :
                 (pend_dir == D_RIGHT) ? ((Box_X > XMAX - STEP_W) ? XMAX : Box_X + STEP_W) : Box_X;
        next_y = (pend_dir == D_UP) ? ((Box_Y < STEP_W) ? '0 : Box_Y - STEP_W) :
                 (pend_dir == D_DOWN) ? ((Box_Y > YMAX - STEP_W) ? YMAX : Box_Y + STEP_W) : Box_Y;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Box_X <= 10'(X_INIT);
            Box_Y <= 10'(Y_INIT);
            Moved <= 1'b0;
        end else begin
            Box_X <= commit ? next_x : Box_X;
            Box_Y <= commit ? next_y : Box_Y;
            Moved <= commit;
        end
    end
endmodule

// File: tb/tb_ir_cursor_mover.sv
// tb_ir_cursor_mover: directed checks of stepping, repeat, clamping, and reset
// on three instances that differ only in their initial position.
module tb_ir_cursor_mover;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, frame_start = 1'b0;
    logic [9:0] bx, by, lo_x, lo_y, hi_x, hi_y;
    logic mv, lo_mv, hi_mv;
    int tests = 0;
    int fails = 0;

    localparam logic [3:0] P_UP = 4'b1000, P_DOWN = 4'b0100, P_LEFT = 4'b0010, P_RIGHT = 4'b0001;

    always #5 clk = ~clk;

    ir_cursor_mover #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
        .Clock(clk), .Reset(rst), .Up(up), .Down(down), .Left(left), .Right(right),
        .Frame_Start(frame_start), .Box_X(bx), .Box_Y(by), .Moved(mv));

    ir_cursor_mover #(.X_INIT(2), .Y_INIT(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut_lo (
        .Clock(clk), .Reset(rst), .Up(up), .Down(down), .Left(left), .Right(right),
        .Frame_Start(frame_start), .Box_X(lo_x), .Box_Y(lo_y), .Moved(lo_mv));

    ir_cursor_mover #(.X_INIT(622), .Y_INIT(462), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut_hi (
        .Clock(clk), .Reset(rst), .Up(up), .Down(down), .Left(left), .Right(right),
        .Frame_Start(frame_start), .Box_X(hi_x), .Box_Y(hi_y), .Moved(hi_mv));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {up, down, left, right} = 4'b0;
        frame_start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input logic [3:0] d, input int n);
        {up, down, left, right} = d;
        repeat (n) tick();
        {up, down, left, right} = 4'b0;
        repeat (5) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bx !== 10'd312) begin fails++; $display("FAIL reset_x got %0d want 312", bx); end
        tests++; if (by !== 10'd232) begin fails++; $display("FAIL reset_y got %0d want 232", by); end
        tests++; if (mv !== 1'b0) begin fails++; $display("FAIL reset_moved got %b want 0", mv); end
        tests++; if (lo_x !== 10'd2 || lo_y !== 10'd1) begin fails++; $display("FAIL reset_lo got %0d,%0d want 2,1", lo_x, lo_y); end
        tests++; if (hi_x !== 10'd622 || hi_y !== 10'd462) begin fails++; $display("FAIL reset_hi got %0d,%0d want 622,462", hi_x, hi_y); end
    endtask

    task automatic test_single_step();
        do_reset();
        press(P_RIGHT, 3);
        tests++; if (bx !== 10'd312 || mv !== 1'b0) begin fails++; $display("FAIL single_precommit got x=%0d mv=%b want 312,0", bx, mv); end
        frame();
        tests++; if (bx !== 10'd316) begin fails++; $display("FAIL single_x got %0d want 316", bx); end
        tests++; if (by !== 10'd232) begin fails++; $display("FAIL single_y got %0d want 232", by); end
        tests++; if (mv !== 1'b1) begin fails++; $display("FAIL single_moved got %b want 1", mv); end
        tick();
        tests++; if (mv !== 1'b0) begin fails++; $display("FAIL single_moved_drop got %b want 0", mv); end
        frame();
        tests++; if (mv !== 1'b0 || bx !== 10'd316) begin fails++; $display("FAIL single_second_frame got x=%0d mv=%b want 316,0", bx, mv); end
    endtask

    task automatic test_repeat();
        int pulses = 0;
        logic exp;
        do_reset();
        right = 1'b1;
        frame_start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp = (i == 4 || i == 12 || i == 16 || i == 20);
            tests++; if (mv !== exp) begin fails++; $display("FAIL repeat_moved cycle %0d got %b want %b", i, mv, exp); end
            if (mv === 1'b1) pulses++;
            if (i == 20) right = 1'b0;
        end
        frame_start = 1'b0;
        tests++; if (pulses != 4) begin fails++; $display("FAIL repeat_pulses got %0d want 4", pulses); end
        tests++; if (bx !== 10'd328) begin fails++; $display("FAIL repeat_x got %0d want 328", bx); end
    endtask

    task automatic test_clamp();
        do_reset();
        press(P_LEFT, 3);
        frame();
        tests++; if (lo_x !== 10'd0 || lo_mv !== 1'b1) begin fails++; $display("FAIL clamp_left got x=%0d mv=%b want 0,1", lo_x, lo_mv); end
        tests++; if (bx !== 10'd308) begin fails++; $display("FAIL clamp_left_mid got %0d want 308", bx); end
        press(P_UP, 3);
        frame();
        tests++; if (lo_y !== 10'd0) begin fails++; $display("FAIL clamp_up got %0d want 0", lo_y); end
        do_reset();
        press(P_RIGHT, 3);
        frame();
        tests++; if (hi_x !== 10'd624 || hi_mv !== 1'b1) begin fails++; $display("FAIL clamp_right got x=%0d mv=%b want 624,1", hi_x, hi_mv); end
        press(P_RIGHT, 3);
        frame();
        tests++; if (hi_x !== 10'd624 || hi_mv !== 1'b1) begin fails++; $display("FAIL clamp_right_again got x=%0d mv=%b want 624,1", hi_x, hi_mv); end
        press(P_DOWN, 3);
        frame();
        tests++; if (hi_y !== 10'd464) begin fails++; $display("FAIL clamp_down got %0d want 464", hi_y); end
    endtask

    task automatic test_conflict();
        do_reset();
        press(P_UP | P_LEFT, 30);
        frame();
        tests++; if (mv !== 1'b0) begin fails++; $display("FAIL conflict_moved got %b want 0", mv); end
        tests++; if (bx !== 10'd312 || by !== 10'd232) begin fails++; $display("FAIL conflict_pos got %0d,%0d want 312,232", bx, by); end
    endtask

    task automatic test_overwrite();
        do_reset();
        press(P_UP, 3);
        press(P_DOWN, 3);
        frame();
        tests++; if (by !== 10'd236 || mv !== 1'b1) begin fails++; $display("FAIL overwrite got y=%0d mv=%b want 236,1", by, mv); end
        tests++; if (bx !== 10'd312) begin fails++; $display("FAIL overwrite_x got %0d want 312", bx); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(P_RIGHT, 3);
        frame();
        tick();
        right = 1'b1;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        right = 1'b0;
        #1;
        tests++; if (bx !== 10'd312 || mv !== 1'b0) begin fails++; $display("FAIL reset_mid_async got x=%0d mv=%b want 312,0", bx, mv); end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        frame();
        tests++; if (mv !== 1'b0 || bx !== 10'd312) begin fails++; $display("FAIL reset_mid_frame got x=%0d mv=%b want 312,0", bx, mv); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_repeat();
        test_clamp();
        test_conflict();
        test_overwrite();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
